// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encodings, next-PC selector, defaults.
// Also imported by the control unit and the bench.
package pc_seq_pkg;

    localparam int unsigned PC_W_DEFAULT  = 8;
    localparam int unsigned CNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_INC    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold, increment, PC-relative branch or absolute jump.
// All arithmetic wraps modulo 2**PC_W.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] i_pc,
    input  pc_sel_e         i_sel,
    input  logic [PC_W-1:0] i_jump_addr,
    input  logic [PC_W-1:0] i_branch_off,
    output logic [PC_W-1:0] o_next_pc
);

    logic [PC_W-1:0] w_pc_inc;

    assign w_pc_inc = i_pc + PC_W'(1);

    always_comb begin
        o_next_pc = i_pc;
        unique case (i_sel)
            SEL_HOLD:   o_next_pc = i_pc;
            SEL_INC:    o_next_pc = w_pc_inc;
            // Offset is two's complement relative to PC+1; plain add wraps correctly.
            SEL_BRANCH: o_next_pc = w_pc_inc + i_branch_off;
            SEL_JUMP:   o_next_pc = i_jump_addr;
            default:    o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC register, stall counter and IDLE/RUN/STALL/HALT FSM.
// The control unit only raises requests; this block decides the next PC each cycle.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned    PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned    CNT_W    = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_halt_req,
    input  logic             i_stall_req,
    input  logic [CNT_W-1:0] i_stall_cycles,
    input  logic             i_jump,
    input  logic [PC_W-1:0]  i_jump_addr,
    input  logic             i_branch_taken,
    input  logic [PC_W-1:0]  i_branch_off,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_pc_en,
    output logic [1:0]       o_state,
    output logic             o_halted
);

    pc_state_e        r_state;
    pc_state_e        w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_next_pc;
    logic             r_pc_en;
    logic             r_halted;
    pc_sel_e          w_sel;

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_next_calc (
        .i_pc         (r_pc),
        .i_sel        (w_sel),
        .i_jump_addr  (i_jump_addr),
        .i_branch_off (i_branch_off),
        .o_next_pc    (w_next_pc)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_sel     = SEL_HOLD;
        unique case (r_state)
            ST_IDLE: begin
                if (i_run) w_state_d = ST_RUN;
            end
            ST_RUN: begin
                // One action per edge; lower-priority requests are dropped, not queued.
                if (i_halt_req) begin
                    w_state_d = ST_HALT;
                end else if (i_stall_req && (i_stall_cycles != '0)) begin
                    w_state_d = ST_STALL;
                    w_cnt_d   = i_stall_cycles;
                end else if (i_jump) begin
                    w_sel = SEL_JUMP;
                end else if (i_branch_taken) begin
                    w_sel = SEL_BRANCH;
                end else begin
                    w_sel = SEL_INC;
                end
            end
            ST_STALL: begin
                if (r_cnt > CNT_W'(1)) begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end else begin
                    w_cnt_d   = '0;
                    w_sel     = SEL_INC;
                    w_state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!i_run) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pc     <= RESET_PC;
            r_pc_en  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_pc     <= w_next_pc;
            r_pc_en  <= (w_next_pc != r_pc);
            r_halted <= (w_state_d == ST_HALT);
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_en  = r_pc_en;
    assign o_state  = r_state;
    assign o_halted = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected PC/state values.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       run;
    logic       halt_req;
    logic       stall_req;
    logic [3:0] stall_cycles;
    logic       jump;
    logic [7:0] jump_addr;
    logic       branch_taken;
    logic [7:0] branch_off;
    logic [7:0] pc;
    logic       pc_en;
    logic [1:0] state;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;

    pc_sequencer #(
        .PC_W     (8),
        .RESET_PC (8'h00),
        .CNT_W    (4)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_run          (run),
        .i_halt_req     (halt_req),
        .i_stall_req    (stall_req),
        .i_stall_cycles (stall_cycles),
        .i_jump         (jump),
        .i_jump_addr    (jump_addr),
        .i_branch_taken (branch_taken),
        .i_branch_off   (branch_off),
        .o_pc           (pc),
        .o_pc_en        (pc_en),
        .o_state        (state),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        halt_req     = 1'b0;
        stall_req    = 1'b0;
        stall_cycles = 4'd0;
        jump         = 1'b0;
        jump_addr    = 8'h00;
        branch_taken = 1'b0;
        branch_off   = 8'h00;
    endtask

    // Single-edge absolute jump from RUN.
    task automatic goto(input logic [7:0] addr);
        clr_req();
        jump      = 1'b1;
        jump_addr = addr;
        tick();
        clr_req();
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        clr_req();
        tick();
        reset = 1'b0;

        // 1: async reset mid-run, no clock edge
        run = 1'b1;
        tick();
        goto(8'h37);
        check_eq("pre_reset_pc", pc, 8'h37);
        check_eq("pre_reset_pc_en", pc_en, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("async_reset_pc", pc, 8'h00);
        check_eq("async_reset_state", state, ST_IDLE);
        check_eq("async_reset_pc_en", pc_en, 0);
        check_eq("async_reset_halted", halted, 0);
        run = 1'b0;
        #1 reset = 1'b0;

        // 2: IDLE -> RUN, then free-running increment
        run = 1'b1;
        check_eq("idle_pc", pc, 8'h00);
        tick();
        check_eq("run_entry_pc", pc, 8'h00);
        check_eq("run_entry_pc_en", pc_en, 0);
        check_eq("run_entry_state", state, ST_RUN);
        tick();
        check_eq("step1_pc", pc, 8'h01);
        check_eq("step1_pc_en", pc_en, 1);
        tick();
        check_eq("step2_pc", pc, 8'h02);
        tick();
        check_eq("step3_pc", pc, 8'h03);
        check_eq("step3_pc_en", pc_en, 1);

        // 3: negative branch offset and PC wrap
        goto(8'h10);
        branch_taken = 1'b1;
        branch_off   = 8'hFC;
        tick();
        clr_req();
        check_eq("branch_back_pc", pc, 8'h0D);
        branch_taken = 1'b1;
        branch_off   = 8'h05;
        tick();
        clr_req();
        check_eq("branch_fwd_pc", pc, 8'h13);
        goto(8'hFF);
        tick();
        check_eq("wrap_pc", pc, 8'h00);

        // 4: jump beats branch; halt beats jump
        goto(8'h05);
        jump         = 1'b1;
        jump_addr    = 8'h80;
        branch_taken = 1'b1;
        branch_off   = 8'h10;
        tick();
        clr_req();
        check_eq("jump_wins_pc", pc, 8'h80);
        goto(8'h05);
        halt_req  = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'h80;
        tick();
        clr_req();
        check_eq("halt_wins_pc", pc, 8'h05);
        check_eq("halt_wins_state", state, ST_HALT);
        check_eq("halt_wins_pc_en", pc_en, 0);
        run = 1'b0;
        tick();
        check_eq("halt_to_idle_state", state, ST_IDLE);
        run = 1'b1;
        tick();
        check_eq("idle_to_run_state", state, ST_RUN);

        // 5: stall for 3 cycles, held branch ignored, then plain step
        goto(8'h20);
        stall_req    = 1'b1;
        stall_cycles = 4'd3;
        branch_taken = 1'b1;
        branch_off   = 8'h10;
        tick();
        stall_req = 1'b0;
        check_eq("stall_c1_pc", pc, 8'h20);
        check_eq("stall_c1_state", state, ST_STALL);
        tick();
        check_eq("stall_c2_pc", pc, 8'h20);
        tick();
        check_eq("stall_c3_pc", pc, 8'h20);
        check_eq("stall_c3_state", state, ST_STALL);
        tick();
        check_eq("stall_done_pc", pc, 8'h21);
        check_eq("stall_done_state", state, ST_RUN);
        check_eq("stall_done_pc_en", pc_en, 1);
        clr_req();
        goto(8'h20);
        stall_req    = 1'b1;
        stall_cycles = 4'd0;
        tick();
        clr_req();
        check_eq("stall_zero_pc", pc, 8'h21);
        check_eq("stall_zero_state", state, ST_RUN);

        // 6: halt, hold while run=1, release through IDLE
        goto(8'h42);
        halt_req = 1'b1;
        tick();
        clr_req();
        check_eq("halt_halted", halted, 1);
        check_eq("halt_pc", pc, 8'h42);
        tick();
        check_eq("halt_hold_state", state, ST_HALT);
        check_eq("halt_hold_pc", pc, 8'h42);
        run = 1'b0;
        tick();
        check_eq("release_state", state, ST_IDLE);
        check_eq("release_pc", pc, 8'h42);
        check_eq("release_halted", halted, 0);
        run = 1'b1;
        tick();
        check_eq("resume_pc", pc, 8'h42);
        tick();
        check_eq("resume_step_pc", pc, 8'h43);

        // Reset during a stall clears counter and state
        stall_req    = 1'b1;
        stall_cycles = 4'd5;
        tick();
        clr_req();
        check_eq("pre_reset_stall_state", state, ST_STALL);
        #1 reset = 1'b1;
        #1;
        check_eq("stall_reset_state", state, ST_IDLE);
        check_eq("stall_reset_pc", pc, 8'h00);
        #1 reset = 1'b0;
        tick();
        tick();
        check_eq("post_stall_reset_pc", pc, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
